audio_sample_fifo: RTL and testbench
====================================

// Module: audio_sample_fifo
// PURPOSE
//   Parametrised byte-to-sample buffer between song_selection (SD byte stream) and frame_assembly.
//   Packs little-endian bytes into BYTES_PER_SAMPLE-wide samples, tags each with a rotating channel index.
//   Stores samples in a DEPTH-entry FIFO; drains with a valid/ready handshake.
//   Replaces the fixed INIT/WRITE/READ byte shuttle with backpressure, flush and fill status.
// PARAMETERS
//   BYTES_PER_SAMPLE  2   bytes per sample, range 1..4; sample width SW = 8*BYTES_PER_SAMPLE
//   CHANNELS          2   channel count, range 1..8; channel tag width CW = max(1,$clog2(CHANNELS))
//   DEPTH             64  FIFO entries, power of 2, range 4..1024
//   AFULL_LEVEL       48  almost_full threshold, range 1..DEPTH
// PORTS
//   clk_25mhz     in   1        system clock
//   rst           in   1        synchronous, active-high reset
//   byte_in       in   8        byte from SD reader
//   byte_valid    in   1        byte_in valid
//   byte_ready    out  1        byte accepted on cycle where byte_valid & byte_ready
//   flush         in   1        synchronous clear of FIFO and assembler
//   sample_out    out  SW       head sample; first-word-fall-through
//   sample_ch     out  CW       channel tag of head sample
//   sample_valid  out  1        head entry present
//   sample_ready  in   1        consumer pops head on sample_valid & sample_ready
//   count         out  clog2(DEPTH+1)  entries stored
//   almost_full   out  1        count >= AFULL_LEVEL
//   overflow      out  1        sticky: byte_valid high while byte_ready low and FIFO full
// BEHAVIOUR
//   Reset: byte_ready=0, sample_valid=0, sample_out=0, sample_ch=0, count=0, almost_full=0, overflow=0;
//     byte_idx=0, ch_ctr=0, rd/wr pointers=0. byte_ready rises the first cycle after rst falls.
//   Assembler: byte_idx counts 0..BYTES_PER_SAMPLE-1; byte k goes to shift reg bits [8k+7:8k] (little-endian).
//   Non-final byte (byte_idx<BPS-1): byte_ready=1 unless flush/rst.
//   Final byte: byte_ready = !full (full = count==DEPTH); pop in same cycle does NOT free room (conservative).
//   Accepting final byte writes {ch_ctr, assembled sample} at wr_ptr same edge; byte_idx->0;
//     ch_ctr increments, wrapping CHANNELS-1 -> 0.
//   Latency: final byte accepted at edge N -> sample_valid=1 after edge N (1 cycle) when previously empty.
//   sample_valid = (count!=0); sample_out/sample_ch = mem[rd_ptr], combinational read.
//   Pop when empty ignored. Simultaneous push+pop: count unchanged, both pointers advance.
//   Pointers are log2(DEPTH) bits, wrap naturally; count tracked separately (full/empty unambiguous).
//   flush (priority over push/pop): pointers, count, byte_idx, ch_ctr -> 0 at next edge;
//     byte_ready=0 during flush cycle; partial sample discarded; overflow NOT cleared (rst only).
//   rst mid-transfer: identical to flush, plus overflow cleared.
//   overflow sets when byte_valid & !byte_ready & full; cleared only by rst.
// CONFIGURATION
//   AUDIO_SIGNED_CONV_EN defined: MSB of each assembled sample inverted on write
//     (offset-binary <-> two's complement for 8-bit WAV); BYTES_PER_SAMPLE==1 only, ignored otherwise.
//   Undefined: samples stored verbatim.
// TESTING
//   BPS=2,CH=2: bytes 34,12,78,56 -> samples 0x1234 ch0, 0x5678 ch1; valid 1 cycle after 2nd byte.
//   DEPTH=4, sample_ready=0: push 4 samples -> count=4, almost_full per level; 5th final byte byte_ready=0, overflow=1.
//   Full + sample_ready=1 + final byte valid: pop occurs, push stalls one cycle, then accepted; count 4->3->4.
//   Send 1 byte of a 2-byte sample, assert flush: count=0, sample_valid=0, next two bytes form fresh ch0 sample.
//   rst asserted with 3 entries and overflow=1: all outputs to reset values next edge; byte_ready=1 after release.
//   AUDIO_SIGNED_CONV_EN, BPS=1: byte 0x80 -> sample_out 0x00; byte 0x7F -> 0xFF.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: packs little-endian SD bytes into channel-tagged samples
// and buffers them in a DEPTH-entry first-word-fall-through FIFO.
//
// Ports:
//   clk_25mhz, rst       clock, synchronous active-high reset
//   byte_in/valid/ready  byte stream in (valid/ready handshake)
//   flush                synchronous clear of FIFO and assembler
//   sample_out/ch/valid  head sample, its channel tag, head present
//   sample_ready         consumer pops head on valid & ready
//   count, almost_full   fill level and count >= AFULL_LEVEL
//   overflow             sticky: byte offered while blocked by a full FIFO
//
// Build option: define AUDIO_SIGNED_CONV_EN to invert the sample MSB on
// write (offset-binary <-> two's complement) when BYTES_PER_SAMPLE == 1.
module audio_sample_fifo #(
  parameter int BYTES_PER_SAMPLE = 2,
  parameter int CHANNELS         = 2,
  parameter int DEPTH            = 64,
  parameter int AFULL_LEVEL      = 48,
  localparam int SW   = 8 * BYTES_PER_SAMPLE,
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic            clk_25mhz,
  input  logic            rst,
  input  logic [7:0]      byte_in,
  input  logic            byte_valid,
  output logic            byte_ready,
  input  logic            flush,
  output logic [SW-1:0]   sample_out,
  output logic [CW-1:0]   sample_ch,
  output logic            sample_valid,
  input  logic            sample_ready,
  output logic [CNTW-1:0] count,
  output logic            almost_full,
  output logic            overflow
);

  localparam int BW = (BYTES_PER_SAMPLE > 1) ?
                      $clog2(BYTES_PER_SAMPLE) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [CW+SW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic [BW-1:0]    r_byte_idx;
  logic [CW-1:0]    r_ch;
  logic [SW-1:0]    r_asm;
  logic             r_overflow;

  logic             w_full;
  logic             w_last;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [SW-1:0]    w_sample;
  logic [SW-1:0]    w_conv;
  logic [CW+SW-1:0] w_head;

  assign w_full = (r_count == CNTW'(DEPTH));
  assign w_last = (r_byte_idx == BW'(BYTES_PER_SAMPLE - 1));

  // Final byte waits for room before the edge; a same-cycle pop does
  // not count as room, which keeps the ready path free of sample_ready.
  assign byte_ready = !rst && !flush && (!w_last || !w_full);

  assign w_accept = byte_valid && byte_ready;
  assign w_push   = w_accept && w_last;
  assign w_pop    = sample_ready && (r_count != '0) && !rst && !flush;

  // Current byte merged into its little-endian slot, so the final byte
  // lands in memory on the same edge it is accepted.
  always_comb begin
    w_sample = r_asm;
    for (int k = 0; k < BYTES_PER_SAMPLE; k++) begin
      if (r_byte_idx == BW'(k)) begin
        w_sample[8*k +: 8] = byte_in;
      end
    end
  end

`ifdef AUDIO_SIGNED_CONV_EN
  always_comb begin
    w_conv = w_sample;
    if (BYTES_PER_SAMPLE == 1) begin
      w_conv = w_sample ^ (SW'(1) << (SW - 1));
    end
  end
`else
  assign w_conv = w_sample;
`endif

  always_ff @(posedge clk_25mhz) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_ch, w_conv};
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
      r_ch       <= '0;
      r_asm      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (byte_valid && !byte_ready && w_full) begin
        r_overflow <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_byte_idx <= '0;
        r_ch       <= '0;
        r_asm      <= '0;
      end else begin
        if (w_accept) begin
          r_asm <= w_sample;
          if (w_last) begin
            r_byte_idx <= '0;
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            if (r_ch == CW'(CHANNELS - 1)) begin
              r_ch <= '0;
            end else begin
              r_ch <= r_ch + CW'(1);
            end
          end else begin
            r_byte_idx <= r_byte_idx + BW'(1);
          end
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        unique case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNTW'(1);
          2'b01:   r_count <= r_count - CNTW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Head is forced to zero when empty so stale memory never shows.
  assign sample_valid = (r_count != '0);
  assign w_head       = sample_valid ? r_mem[r_rd_ptr] : '0;
  assign sample_out   = w_head[SW-1:0];
  assign sample_ch    = w_head[CW+SW-1:SW];
  assign count        = r_count;
  assign almost_full  = (r_count >= CNTW'(AFULL_LEVEL));
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed and randomized checks of audio_sample_fifo
// against a queue-based reference model.
module tb_audio_sample_fifo;

  localparam int BPS   = 2;
  localparam int CH    = 2;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;
  localparam int SW    = 16;
  localparam int CW    = 1;
  localparam int CNTW  = 3;

  logic            clk_25mhz = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      byte_in = 8'h00;
  logic            byte_valid = 1'b0;
  logic            byte_ready;
  logic            flush = 1'b0;
  logic [SW-1:0]   sample_out;
  logic [CW-1:0]   sample_ch;
  logic            sample_valid;
  logic            sample_ready = 1'b0;
  logic [CNTW-1:0] count;
  logic            almost_full;
  logic            overflow;

  audio_sample_fifo #(
    .BYTES_PER_SAMPLE(BPS),
    .CHANNELS(CH),
    .DEPTH(DEPTH),
    .AFULL_LEVEL(AFL)
  ) dut (
    .clk_25mhz(clk_25mhz),
    .rst(rst),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .flush(flush),
    .sample_out(sample_out),
    .sample_ch(sample_ch),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .count(count),
    .almost_full(almost_full),
    .overflow(overflow)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int n_chk = 0;
  int n_fail = 0;

  int m_s[$];
  int m_c[$];
  int m_part[$];
  int m_ch = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit bv,
                      input logic [7:0] b, input bit sr);
    bit er;
    int hs;
    int hc;
    int smp;
    @(negedge clk_25mhz);
    rst = r;
    flush = f;
    byte_valid = bv;
    byte_in = b;
    sample_ready = sr;
    #1;
    er = !r && !f &&
         (m_part.size() < BPS - 1 || m_s.size() < DEPTH);
    hs = (m_s.size() != 0) ? m_s[0] : 0;
    hc = (m_s.size() != 0) ? m_c[0] : 0;
    chk("byte_ready", byte_ready, er);
    chk("sample_valid", sample_valid, m_s.size() != 0);
    chk("sample_out", sample_out, hs);
    chk("sample_ch", sample_ch, hc);
    chk("count", count, m_s.size());
    chk("almost_full", almost_full, m_s.size() >= AFL);
    chk("overflow", overflow, m_ovf);
    if (r) begin
      m_ovf = 1'b0;
    end else if (bv && !er && m_s.size() == DEPTH) begin
      m_ovf = 1'b1;
    end
    if (r || f) begin
      m_s.delete();
      m_c.delete();
      m_part.delete();
      m_ch = 0;
    end else begin
      if (sr && m_s.size() != 0) begin
        void'(m_s.pop_front());
        void'(m_c.pop_front());
      end
      if (bv && er) begin
        m_part.push_back(int'(b));
        if (m_part.size() == BPS) begin
          smp = 0;
          for (int k = 0; k < BPS; k++) begin
            smp += m_part[k] << (8 * k);
          end
          m_s.push_back(smp);
          m_c.push_back(m_ch);
          m_ch = (m_ch + 1) % CH;
          m_part.delete();
        end
      end
    end
  endtask

  task automatic post(input string tag, input bit v, input int s,
                      input int c, input int n, input bit ov);
    @(posedge clk_25mhz);
    #1;
    chk({tag, ".valid"}, sample_valid, v);
    chk({tag, ".out"}, sample_out, s);
    chk({tag, ".ch"}, sample_ch, c);
    chk({tag, ".count"}, count, n);
    chk({tag, ".ovf"}, overflow, ov);
  endtask

  task automatic push_sample(input logic [15:0] s);
    step(0, 0, 1, s[7:0], 0);
    step(0, 0, 1, s[15:8], 0);
  endtask

  initial begin
    bit rr;
    bit ff;
    bit bb;
    bit ss;
    int bias;
    repeat (2) @(posedge clk_25mhz);
    step(1, 0, 0, 8'h00, 0);
    step(1, 0, 1, 8'h55, 1);

    step(0, 0, 1, 8'h34, 0);
    step(0, 0, 1, 8'h12, 0);
    post("first", 1, 'h1234, 0, 1, 0);
    step(0, 0, 1, 8'h78, 0);
    step(0, 0, 1, 8'h56, 0);
    post("second", 1, 'h1234, 0, 2, 0);
    step(0, 0, 0, 8'h00, 1);
    post("pop1", 1, 'h5678, 1, 1, 0);
    step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);

    step(0, 1, 0, 8'h00, 0);
    push_sample(16'h1111);
    push_sample(16'h2222);
    push_sample(16'h3333);
    chk("afull_at_3", almost_full, 1'b0);
    push_sample(16'h4444);
    post("full", 1, 'h1111, 0, 4, 0);
    chk("afull_full", almost_full, 1'b1);
    step(0, 0, 1, 8'hAA, 0);
    step(0, 0, 1, 8'hBB, 0);
    post("ovf", 1, 'h1111, 0, 4, 1);
    step(0, 0, 1, 8'hBB, 1);
    post("stall", 1, 'h2222, 1, 3, 1);
    step(0, 0, 1, 8'hBB, 0);
    post("refill", 1, 'h2222, 1, 4, 1);

    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'hEE, 0);
    step(0, 1, 1, 8'hDD, 0);
    post("flush", 0, 0, 0, 0, 1);
    step(0, 0, 1, 8'hCD, 0);
    step(0, 0, 1, 8'hAB, 0);
    post("fresh", 1, 'hABCD, 0, 1, 1);

    push_sample(16'h0102);
    push_sample(16'h0304);
    step(0, 0, 0, 8'h00, 0);
    chk("pre_rst_cnt", count, 3);
    step(1, 0, 1, 8'h99, 1);
    post("rst", 0, 0, 0, 0, 0);
    chk("rst_ready", byte_ready, 1'b0);
    step(0, 0, 0, 8'h00, 0);

    bias = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) begin
        bias = $urandom_range(1, 9);
      end
      rr = ($urandom_range(0, 299) == 0);
      ff = ($urandom_range(0, 79) == 0);
      bb = ($urandom_range(0, 9) < 7);
      ss = ($urandom_range(0, 9) < bias);
      step(rr, ff, bb, 8'($urandom), ss);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
